// File: rtl/lsu_split_pkg.sv
// Shared constants for the split-capable load/store unit: FSM encodings,
// access sizes and the fixed AXI fields.
package lsu_split_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_RREQ  = 3'd1;
    localparam state_t S_RRESP = 3'd2;
    localparam state_t S_WREQ  = 3'd3;
    localparam state_t S_WADDR = 3'd4;
    localparam state_t S_WDATA = 3'd5;
    localparam state_t S_WRESP = 3'd6;
    localparam state_t S_HOLD  = 3'd7;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [7:0] AXI_LEN        = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_ID         = 4'd0;
    localparam logic       AXI_WLAST      = 1'b1;

    // A doubleword access cannot be expressed by a 32-bit datapath.
    function automatic logic size_illegal(input logic [1:0] sz, input int xlen);
        return (sz == SZ_D) && (xlen < 64);
    endfunction

endpackage

// File: rtl/lsu_split_align.sv
// Combinational address/lane logic: beat addresses and sizes, store lane
// placement with strobes, and load byte extraction with sign/zero extension.
module lsu_split_align
    import lsu_split_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int BUS_W = 32
) (
    input  logic [2:0]           ls,
    input  logic [31:0]          addr,
    input  logic [XLEN-1:0]      wdata,
    input  logic                 beat,
    input  logic [2*BUS_W-1:0]   merge,
    output logic                 split,
    output logic [31:0]          beat_addr,
    output logic [2:0]           beat_size,
    output logic [BUS_W-1:0]     beat_wdata,
    output logic [BUS_W/8-1:0]   beat_wstrb,
    output logic [XLEN-1:0]      ldata
);

    localparam int BB   = BUS_W / 8;
    localparam int OFFW = $clog2(BB);
    localparam int XB   = XLEN / 8;

    logic [OFFW-1:0]      off;
    logic [3:0]           nbytes;
    logic [31:0]          aligned;
    logic [8:0]           mask;
    logic [2*BUS_W-1:0]   wide_wdata;
    logic [2*BB-1:0]      wide_strb;
    logic [XLEN-1:0]      shifted;
    logic                 msb;
    logic [7:0]           fill;

    assign off     = addr[OFFW-1:0];
    assign nbytes  = 4'd1 << ls[1:0];
    assign split   = (5'(off) + 5'(nbytes)) > 5'(BB);
    assign aligned = {addr[31:OFFW], {OFFW{1'b0}}};

    assign beat_addr = split ? (aligned + (beat ? 32'(BB) : 32'd0)) : addr;
    assign beat_size = split ? 3'(OFFW) : {1'b0, ls[1:0]};

    // Stores are laid out over two bus words; each beat drives one half.
    assign mask       = (9'd1 << nbytes) - 9'd1;
    assign wide_wdata = (2*BUS_W)'(wdata) << {off, 3'b000};
    assign wide_strb  = (2*BB)'(mask) << off;
    assign beat_wdata = beat ? wide_wdata[2*BUS_W-1:BUS_W] : wide_wdata[BUS_W-1:0];
    assign beat_wstrb = beat ? wide_strb[2*BB-1:BB] : wide_strb[BB-1:0];

    assign shifted = XLEN'(merge >> {off, 3'b000});

    always_comb begin
        case (ls[1:0])
            SZ_B:    msb = shifted[7];
            SZ_H:    msb = shifted[15];
            SZ_W:    msb = shifted[31];
            default: msb = shifted[XLEN-1];
        endcase
    end

    assign fill = (ls[2] && msb) ? 8'hFF : 8'h00;

    generate
        for (genvar gi = 0; gi < XB; gi++) begin : g_ext
            assign ldata[gi*8 +: 8] = (4'(gi) < nbytes) ? shifted[gi*8 +: 8] : fill;
        end
    endgenerate

endmodule

// File: rtl/lsu_split.sv
// Load/store unit with separate AXI read/write channels, misaligned access
// splitting into two beats, bus-error reporting and flush at any point.
module lsu_split
    import lsu_split_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int BUS_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           ls,
    input  logic [XLEN-1:0]      addr,
    input  logic [XLEN-1:0]      wdata,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_rdata,
    output logic                 out_fault,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [31:0]          araddr,
    output logic [2:0]           arsize,
    output logic [7:0]           arlen,
    output logic [1:0]           arburst,
    output logic [3:0]           arid,
    input  logic                 rvalid,
    output logic                 rready,
    input  logic [BUS_W-1:0]     rdata,
    input  logic [1:0]           rresp,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [31:0]          awaddr,
    output logic [2:0]           awsize,
    output logic [7:0]           awlen,
    output logic [1:0]           awburst,
    output logic [3:0]           awid,
    output logic                 wvalid,
    input  logic                 wready,
    output logic [BUS_W-1:0]     axi_wdata,
    output logic [BUS_W/8-1:0]   wstrb,
    output logic                 wlast,
    input  logic                 bvalid,
    output logic                 bready,
    input  logic [1:0]           bresp
);

    state_t              state_reg, state_next;
    logic                drop_reg, drop_next;
    logic                fault_reg, fault_next;
    logic                beat_reg, beat_next;
    logic [2*BUS_W-1:0]  merge_reg, merge_next;
    logic [3:0]          ls_reg, ls_next;
    logic [XLEN-1:0]     addr_reg, addr_next;
    logic [XLEN-1:0]     wdata_reg, wdata_next;

    logic                accept;
    logic                done;
    logic                bus_state;
    logic                split;
    logic [31:0]         beat_addr;
    logic [2:0]          beat_size;
    logic [XLEN-1:0]     ldata;

    lsu_split_align #(.XLEN(XLEN), .BUS_W(BUS_W)) u_align (
        .ls         (ls_reg[2:0]),
        .addr       (addr_reg[31:0]),
        .wdata      (wdata_reg),
        .beat       (beat_reg),
        .merge      (merge_reg),
        .split      (split),
        .beat_addr  (beat_addr),
        .beat_size  (beat_size),
        .beat_wdata (axi_wdata),
        .beat_wstrb (wstrb),
        .ldata      (ldata)
    );

    assign in_ready  = ((state_reg == S_IDLE) || ((state_reg == S_HOLD) && out_ready)) && !flush;
    assign accept    = in_ready && in_valid;
    assign bus_state = (state_reg != S_IDLE) && (state_reg != S_HOLD);

    always_comb begin
        state_next = state_reg;
        drop_next  = drop_reg;
        fault_next = fault_reg;
        beat_next  = beat_reg;
        merge_next = merge_reg;
        ls_next    = ls_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        done       = 1'b0;

        case (state_reg)
            S_RREQ:  if (arready) state_next = S_RRESP;
            S_RRESP: begin
                if (rvalid) begin
                    if (beat_reg) merge_next[2*BUS_W-1:BUS_W] = rdata;
                    else          merge_next[BUS_W-1:0]       = rdata;
                    if (rresp != RESP_OKAY) begin
                        fault_next = 1'b1;
                        done       = 1'b1;
                    end else if (split && !beat_reg) begin
                        beat_next  = 1'b1;
                        state_next = S_RREQ;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            S_WREQ: begin
                case ({awready, wready})
                    2'b11:   state_next = S_WRESP;
                    2'b10:   state_next = S_WDATA;
                    2'b01:   state_next = S_WADDR;
                    default: state_next = S_WREQ;
                endcase
            end
            S_WADDR: if (awready) state_next = S_WRESP;
            S_WDATA: if (wready)  state_next = S_WRESP;
            S_WRESP: begin
                if (bvalid) begin
                    if (bresp != RESP_OKAY) begin
                        fault_next = 1'b1;
                        done       = 1'b1;
                    end else if (split && !beat_reg) begin
                        beat_next  = 1'b1;
                        state_next = S_WREQ;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (flush || (out_ready && !in_valid)) state_next = S_IDLE;
            end
            default: ;
        endcase

        // Bus handshakes are never withdrawn; a flush only suppresses the result.
        if (bus_state && flush) drop_next = 1'b1;

        if (done) begin
            if (drop_reg || flush) begin
                state_next = S_IDLE;
                drop_next  = 1'b0;
            end else begin
                state_next = S_HOLD;
            end
        end

        if (accept) begin
            ls_next    = ls;
            addr_next  = addr;
            wdata_next = wdata;
            merge_next = '0;
            beat_next  = 1'b0;
            drop_next  = 1'b0;
            fault_next = size_illegal(ls[1:0], XLEN);
            if (size_illegal(ls[1:0], XLEN)) state_next = S_HOLD;
            else if (ls[3])                  state_next = S_RREQ;
            else                             state_next = S_WREQ;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            drop_reg  <= 1'b0;
            fault_reg <= 1'b0;
            beat_reg  <= 1'b0;
            merge_reg <= '0;
            ls_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            drop_reg  <= drop_next;
            fault_reg <= fault_next;
            beat_reg  <= beat_next;
            merge_reg <= merge_next;
            ls_reg    <= ls_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    assign arvalid = (state_reg == S_RREQ);
    assign rready  = (state_reg == S_RRESP);
    assign awvalid = (state_reg == S_WREQ) || (state_reg == S_WADDR);
    assign wvalid  = (state_reg == S_WREQ) || (state_reg == S_WDATA);
    assign bready  = (state_reg == S_WRESP);

    assign araddr  = beat_addr;
    assign awaddr  = beat_addr;
    assign arsize  = beat_size;
    assign awsize  = beat_size;
    assign arlen   = AXI_LEN;
    assign awlen   = AXI_LEN;
    assign arburst = AXI_BURST_INCR;
    assign awburst = AXI_BURST_INCR;
    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign wlast   = AXI_WLAST;

    assign out_valid = (state_reg == S_HOLD);
    assign out_fault = (state_reg == S_HOLD) && fault_reg;
    assign out_rdata = ((state_reg == S_HOLD) && ls_reg[3] && !fault_reg) ? ldata : '0;

endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split (XLEN=32, BUS_W=32) with a hand-driven AXI slave.
module tb_lsu_split;

    localparam int XLEN  = 32;
    localparam int BUS_W = 32;

    logic              clock = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_ready, out_valid, out_fault;
    logic [3:0]        ls;
    logic [XLEN-1:0]   addr, wdata, out_rdata;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       araddr, awaddr;
    logic [2:0]        arsize, awsize;
    logic [7:0]        arlen, awlen;
    logic [1:0]        arburst, awburst, rresp, bresp;
    logic [3:0]        arid, awid;
    logic [BUS_W-1:0]  rdata, axi_wdata;
    logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [BUS_W/8-1:0] wstrb;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    lsu_split #(.XLEN(XLEN), .BUS_W(BUS_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .ls(ls), .addr(addr), .wdata(wdata),
        .out_ready(out_ready), .out_valid(out_valid), .out_rdata(out_rdata), .out_fault(out_fault),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
        .arlen(arlen), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
        .awlen(awlen), .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .axi_wdata(axi_wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; flush = 0; in_valid = 0; ls = 0; addr = 0; wdata = 0; out_ready = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;

        // Reset state
        repeat (3) cyc();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_bus_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        check("rst_out_rdata", out_rdata, 0);
        check("fixed_fields", {arlen, arburst, arid, awlen, awburst, awid, wlast}, {8'd0, 2'b01, 4'd0, 8'd0, 2'b01, 4'd0, 1'b1});
        reset = 1;
        cyc();

        // Aligned lw @0x80000004, zero-wait slave
        arready = 1; rvalid = 1; rdata = 32'h12345678;
        in_valid = 1; ls = 4'b1010; addr = 32'h80000004; #1;
        check("t1_accept", in_ready, 1);
        cyc(); in_valid = 0;
        check("t1_ar", {arvalid, araddr, arsize}, {1'b1, 32'h80000004, 3'd2});
        check("t1_no_out_n1", out_valid, 0);
        cyc();
        check("t1_rready", {rready, arvalid, out_valid}, 3'b100);
        cyc();
        check("t1_result", {out_valid, out_fault, out_rdata}, {1'b1, 1'b0, 32'h12345678});
        $display("txn lw aligned: rdata=%h", out_rdata);
        out_ready = 1; cyc(); out_ready = 0;
        check("t1_idle", {out_valid, in_ready}, 2'b01);

        // Split lw @0x80000003
        rdata = 32'hDDCCBBAA;
        in_valid = 1; ls = 4'b1010; addr = 32'h80000003;
        cyc(); in_valid = 0;
        check("t2_ar0", {arvalid, araddr, arsize}, {1'b1, 32'h80000000, 3'd2});
        cyc();
        check("t2_r0", rready, 1);
        cyc(); rdata = 32'h44332211;
        check("t2_ar1", {arvalid, araddr}, {1'b1, 32'h80000004});
        cyc();
        check("t2_r1", {rready, out_valid}, 2'b10);
        cyc();
        check("t2_result", {out_valid, out_fault, out_rdata}, {1'b1, 1'b0, 32'h332211DD});
        $display("txn lw split: rdata=%h", out_rdata);
        out_ready = 1; cyc(); out_ready = 0;

        // Split sh 0xBEEF @0x80000003, beat1 goes through WADDR
        arready = 0; rvalid = 0;
        awready = 1; wready = 1; bvalid = 1; bresp = 0;
        in_valid = 1; ls = 4'b0001; addr = 32'h80000003; wdata = 32'h0000BEEF;
        cyc(); in_valid = 0;
        check("t3_w0", {awvalid, wvalid, awaddr, awsize, wstrb, axi_wdata},
              {1'b1, 1'b1, 32'h80000000, 3'd2, 4'b1000, 32'hEF000000});
        cyc(); awready = 0;
        check("t3_b0", bready, 1);
        cyc();
        check("t3_w1", {awvalid, wvalid, awaddr, wstrb, axi_wdata},
              {1'b1, 1'b1, 32'h80000004, 4'b0001, 32'h000000BE});
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("t3_waddr_wait", {awvalid, wvalid}, 2'b10);
        end
        cyc(); awready = 1;
        check("t3_waddr_hs", {awvalid, wvalid}, 2'b10);
        cyc();
        check("t3_b1", bready, 1);
        cyc();
        check("t3_result", {out_valid, out_fault, out_rdata}, {1'b1, 1'b0, 32'h0});
        $display("txn sh split: fault=%b", out_fault);
        out_ready = 1; cyc(); out_ready = 0;
        awready = 0; wready = 0; bvalid = 0;

        // Split lw with beat0 error: no second AR
        arready = 1; rvalid = 1; rresp = 2'd2; rdata = 32'hDDCCBBAA;
        in_valid = 1; ls = 4'b1010; addr = 32'h80000003;
        cyc(); in_valid = 0;
        cyc();
        cyc();
        check("t4_fault", {out_valid, out_fault, out_rdata, arvalid}, {1'b1, 1'b1, 32'h0, 1'b0});
        $display("txn lw split err: fault=%b rdata=%h", out_fault, out_rdata);
        out_ready = 1; cyc(); out_ready = 0;
        rresp = 0;

        // Doubleword load on a 32-bit datapath: fault without bus activity
        in_valid = 1; ls = 4'b1011; addr = 32'h80000000;
        cyc(); in_valid = 0;
        check("t5_illegal", {out_valid, out_fault, arvalid, awvalid}, 4'b1100);
        $display("txn ld illegal: fault=%b", out_fault);
        out_ready = 1; cyc(); out_ready = 0;

        // Flush one cycle after accept; arready delayed 5 cycles
        arready = 0; rvalid = 0;
        in_valid = 1; ls = 4'b1010; addr = 32'h80000008;
        cyc(); in_valid = 0; flush = 1; #1;
        check("t6_flush_in_ready", {arvalid, in_ready}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            cyc(); flush = 0;
            check("t6_ar_held", arvalid, 1);
        end
        cyc(); arready = 1;
        check("t6_ar_held_last", arvalid, 1);
        cyc(); arready = 0; rvalid = 1; rdata = 32'hCAFEF00D;
        check("t6_rresp", {rready, out_valid}, 2'b10);
        cyc();
        check("t6_dropped", {out_valid, in_ready, arvalid}, 3'b010);
        $display("txn lw flushed: out_valid=%b", out_valid);

        // Signed lb, held result, then back-to-back lhu
        arready = 1; rvalid = 1; rdata = 32'h00008000;
        in_valid = 1; ls = 4'b1100; addr = 32'h80000001;
        cyc(); in_valid = 0;
        cyc(); cyc();
        check("t7_lb", {out_valid, out_rdata}, {1'b1, 32'hFFFFFF80});
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t7_stable", {out_valid, out_fault, in_ready, out_rdata}, {3'b100, 32'hFFFFFF80});
        end
        $display("txn lb signed: rdata=%h", out_rdata);
        rdata = 32'hABCD0000;
        out_ready = 1; in_valid = 1; ls = 4'b1001; addr = 32'h80000002; #1;
        check("t7_b2b_accept", in_ready, 1);
        cyc(); out_ready = 0; in_valid = 0;
        check("t7_b2b_ar", {out_valid, arvalid, araddr, arsize}, {1'b0, 1'b1, 32'h80000002, 3'd1});
        cyc(); cyc();
        check("t7_lhu", {out_valid, out_rdata}, {1'b1, 32'h0000ABCD});
        $display("txn lhu b2b: rdata=%h", out_rdata);

        // Flush while holding a result discards it
        flush = 1; #1;
        check("t8_flush_hold_ready", in_ready, 0);
        cyc(); flush = 0; #1;
        check("t8_flush_hold", {out_valid, in_ready, out_rdata}, {2'b01, 32'h0});
        arready = 0; rvalid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
